// File: rtl/barrel_thread_scheduler.sv
// barrel_thread_scheduler: round-robin fetch thread picker with per-thread re-issue cooldown
module barrel_thread_scheduler #(
  parameter int BITS_THREADS = 3,
  parameter int MIN_SPACING = 5,
  localparam int NUM_THREADS = 2 ** BITS_THREADS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_busy,
  input  logic                    start_req,
  input  logic [BITS_THREADS-1:0] start_tid,
  input  logic                    halt_req,
  input  logic [BITS_THREADS-1:0] halt_tid,
  output logic                    stall,
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] issue_tid,
  output logic [NUM_THREADS-1:0]  running_mask,
  output logic                    all_halted
);
  localparam int CW = MIN_SPACING > 1 ? $clog2(MIN_SPACING) : 1;
  logic [NUM_THREADS-1:0] run_q, run_d;
  logic [CW-1:0] cnt_q [NUM_THREADS];
  logic [CW-1:0] cnt_d [NUM_THREADS];
  logic [BITS_THREADS-1:0] last_q, last_d, tid_q, tid_d, win, idx;
  logic valid_q, valid_d, found;
  always_comb begin
    found = 1'b0;
    win = last_q;
    idx = last_q;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = last_q + BITS_THREADS'(i);
      if (!found && run_q[idx] && cnt_q[idx] == '0) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    run_d = run_q;
    if (halt_req) run_d[halt_tid] = 1'b0;
    if (start_req) run_d[start_tid] = 1'b1;
    valid_d = valid_q;
    tid_d = tid_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (!mem_busy) begin
      valid_d = found;
      tid_d = found ? win : tid_q;
      last_d = found ? win : last_q;
      for (int t = 0; t < NUM_THREADS; t++)
        cnt_d[t] = (found && win == BITS_THREADS'(t)) ? CW'(MIN_SPACING - 1) :
                   (cnt_q[t] != '0 ? cnt_q[t] - CW'(1) : '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= NUM_THREADS'(1);
      cnt_q <= '{default: '0};
      last_q <= BITS_THREADS'(NUM_THREADS - 1);
      tid_q <= '0;
      valid_q <= 1'b0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      tid_q <= tid_d;
      valid_q <= valid_d;
    end
  end
  assign stall = mem_busy;
  assign issue_valid = valid_q;
  assign issue_tid = tid_q;
  assign running_mask = run_q;
  assign all_halted = run_q == '0;
endmodule

// File: tb/tb_barrel_thread_scheduler.sv
// tb_barrel_thread_scheduler: scoreboard plus per-scenario checks for barrel_thread_scheduler
module tb_barrel_thread_scheduler;
  localparam int B = 3;
  localparam int N = 8;
  localparam int MS = 5;
  logic clk = 1'b0, rst_n = 1'b0, mem_busy = 1'b0, start_req = 1'b0, halt_req = 1'b0;
  logic [B-1:0] start_tid = '0, halt_tid = '0;
  logic stall, issue_valid, all_halted;
  logic [B-1:0] issue_tid;
  logic [N-1:0] running_mask;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic v;
    logic [B-1:0] t;
    logic [N-1:0] m;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  bit [N-1:0] m_run;
  bit m_v;
  bit [B-1:0] m_t;
  int m_last, m_adv;
  int m_iss[N];

  barrel_thread_scheduler #(.BITS_THREADS(B), .MIN_SPACING(MS)) dut (
    .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .start_req(start_req), .start_tid(start_tid),
    .halt_req(halt_req), .halt_tid(halt_tid), .stall(stall), .issue_valid(issue_valid),
    .issue_tid(issue_tid), .running_mask(running_mask), .all_halted(all_halted)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_run = N'(1);
    m_v = 1'b0;
    m_t = '0;
    m_last = N - 1;
    m_adv = 0;
    for (int t = 0; t < N; t++) m_iss[t] = -MS;
  endfunction

  // a thread is eligible once MS advancing cycles have passed since its last issue
  function automatic void model_step(input logic busy, sreq, input logic [B-1:0] stid,
                                     input logic hreq, input logic [B-1:0] htid);
    int w;
    if (!busy) begin
      w = -1;
      for (int i = 1; i <= N; i++) begin
        int t;
        t = (m_last + i) % N;
        if (w < 0 && m_run[t] && m_adv - m_iss[t] >= MS) w = t;
      end
      if (w >= 0) begin
        m_v = 1'b1;
        m_t = w[B-1:0];
        m_last = w;
        m_iss[w] = m_adv;
      end else m_v = 1'b0;
      m_adv++;
    end
    if (hreq) m_run[htid] = 1'b0;
    if (sreq) m_run[stid] = 1'b1;
  endfunction

  task automatic cyc(input logic busy, sreq, input logic [B-1:0] stid,
                     input logic hreq, input logic [B-1:0] htid);
    mem_busy = busy;
    start_req = sreq;
    start_tid = stid;
    halt_req = hreq;
    halt_tid = htid;
    model_step(busy, sreq, stid, hreq, htid);
    sb.push_back('{m_v, m_t, m_run});
    @(posedge clk);
    #2;
    start_req = 1'b0;
    halt_req = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({issue_valid, issue_tid, running_mask, all_halted} !== {e.v, e.t, e.m, e.m == '0}) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got v=%b tid=%0d mask=%b halted=%b expected v=%b tid=%0d mask=%b halted=%b",
                 $time, issue_valid, issue_tid, running_mask, all_halted, e.v, e.t, e.m, e.m == '0);
      end
    end
  end

  task automatic test_reset();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({issue_valid, issue_tid, running_mask, all_halted} !== {1'b0, 3'd0, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got v=%b tid=%0d mask=%b halted=%b expected v=0 tid=0 mask=00000001 halted=0",
               issue_valid, issue_tid, running_mask, all_halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (issue_valid !== pat[i] || issue_tid !== 3'd0) begin
        failures++;
        $display("FAIL single_thread_spacing[%0d]: got v=%b tid=%0d expected v=%b tid=0", i, issue_valid, issue_tid, pat[i]);
      end
    end
  endtask

  task automatic test_start_all();
    logic [B-1:0] prev;
    for (int i = 1; i < N; i++) cyc(0, 1, B'(i), 0, 0);
    repeat (16) cyc(0, 0, 0, 0, 0);
    prev = issue_tid;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (issue_valid !== 1'b1 || issue_tid !== prev + 3'd1) begin
        failures++;
        $display("FAIL round_robin[%0d]: got v=%b tid=%0d expected v=1 tid=%0d", i, issue_valid, issue_tid, prev + 3'd1);
      end
      prev = issue_tid;
    end
  endtask

  task automatic test_busy();
    logic [B-1:0] pt;
    logic pv;
    pt = issue_tid;
    pv = issue_valid;
    mem_busy = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL stall_comb: got %b expected 1", stall);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      checks++;
      if (stall !== 1'b1 || issue_tid !== pt || issue_valid !== pv) begin
        failures++;
        $display("FAIL busy_freeze[%0d]: got stall=%b v=%b tid=%0d expected stall=1 v=%b tid=%0d",
                 i, stall, issue_valid, issue_tid, pv, pt);
      end
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || issue_valid !== 1'b1 || issue_tid !== pt + 3'd1) begin
      failures++;
      $display("FAIL busy_resume: got stall=%b v=%b tid=%0d expected stall=0 v=1 tid=%0d",
               stall, issue_valid, issue_tid, pt + 3'd1);
    end
  endtask

  task automatic test_halt();
    logic [B-1:0] prev;
    cyc(0, 0, 0, 1, 3);
    checks++;
    if (running_mask[3] !== 1'b0) begin
      failures++;
      $display("FAIL halt_mask: got %b expected 0", running_mask[3]);
    end
    for (int i = 0; i < 16; i++) begin
      prev = issue_tid;
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (issue_valid !== 1'b1 || issue_tid === 3'd3 || (prev == 3'd2 && issue_tid !== 3'd4)) begin
        failures++;
        $display("FAIL halt_skip[%0d]: got v=%b tid=%0d after %0d expected v=1 tid!=3", i, issue_valid, issue_tid, prev);
      end
    end
  endtask

  task automatic test_start_halt();
    cyc(0, 0, 0, 1, 5);
    cyc(0, 1, 5, 1, 5);
    checks++;
    if (running_mask[5] !== 1'b1) begin
      failures++;
      $display("FAIL start_wins: got %b expected 1", running_mask[5]);
    end
    cyc(0, 1, 3, 1, 6);
    checks++;
    if (running_mask[3] !== 1'b1 || running_mask[6] !== 1'b0) begin
      failures++;
      $display("FAIL both_apply: got m3=%b m6=%b expected m3=1 m6=0", running_mask[3], running_mask[6]);
    end
    for (int t = 0; t < N; t++) cyc(0, 0, 0, 1, B'(t));
    checks++;
    if (running_mask !== '0 || all_halted !== 1'b1) begin
      failures++;
      $display("FAIL all_halted: got mask=%b halted=%b expected mask=00000000 halted=1", running_mask, all_halted);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (issue_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_bubble[%0d]: got %b expected 0", i, issue_valid);
      end
    end
    cyc(0, 1, 2, 0, 0);
    checks++;
    if (issue_valid !== 1'b0 || running_mask !== 8'h04) begin
      failures++;
      $display("FAIL restart_edge1: got v=%b mask=%b expected v=0 mask=00000100", issue_valid, running_mask);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd2) begin
      failures++;
      $display("FAIL restart_edge2: got v=%b tid=%0d expected v=1 tid=2", issue_valid, issue_tid);
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 1, 5, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({issue_valid, issue_tid, running_mask, all_halted} !== {1'b0, 3'd0, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got v=%b tid=%0d mask=%b halted=%b expected v=0 tid=0 mask=00000001 halted=0",
               issue_valid, issue_tid, running_mask, all_halted);
    end
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 1'b1 || issue_tid !== 3'd0) begin
      failures++;
      $display("FAIL post_reset_issue: got v=%b tid=%0d expected v=1 tid=0", issue_valid, issue_tid);
    end
    repeat (6) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start_all();
    test_busy();
    test_halt();
    test_start_halt();
    test_async_reset();
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
